i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target (slave) with a local register file.
// Answers to DEV_ADDR. A write transaction sets the register pointer with its
// first data byte and writes the following bytes at auto-incrementing
// addresses. A read transaction streams bytes from the pointer until NACK.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   SCL_IN, SDA_IN            raw bus lines, asynchronous to clk
//   SDA_OE                    1 = pull SDA low (open-drain driver enable)
//   host_wr_en/addr/data      local write port into the register file
//   bus_wr_valid/addr/data    one-cycle notification of each byte written over I2C
//   busy                      target is engaged in an addressed transaction
module i2c_target #(
   parameter logic [6:0]  DEV_ADDR = 7'h1D,
   parameter int unsigned NUM_REGS = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SCL_IN,
   input  logic       SDA_IN,
   output logic       SDA_OE,
   input  logic       host_wr_en,
   input  logic [7:0] host_wr_addr,
   input  logic [7:0] host_wr_data,
   output logic       bus_wr_valid,
   output logic [7:0] bus_wr_addr,
   output logic [7:0] bus_wr_data,
   output logic       busy
);

   localparam int unsigned AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0]  LAST_ADDR = 8'(NUM_REGS - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_ADDR_ACK,
      ST_REG_ADDR,
      ST_REG_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_t;

   state_t     state;
   logic [7:0] regs [NUM_REGS];
   logic [7:0] ptr;
   logic [7:0] ptr_next;
   logic [7:0] shift;
   logic [7:0] tx_byte;
   logic [3:0] bit_cnt;
   logic       rw;
   logic [7:0] rd_cur;
   logic [7:0] rd_next;

   logic scl_meta, scl_sync, scl_prev;
   logic sda_meta, sda_sync, sda_prev;
   logic scl_rise, scl_fall, start_det, stop_det;

   function automatic logic in_range(input logic [7:0] a);
      return {24'h0, a} < NUM_REGS;
   endfunction

   // Two-flop synchronizers plus one history stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_meta <= 1'b1;
         scl_sync <= 1'b1;
         scl_prev <= 1'b1;
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_meta <= SCL_IN;
         scl_sync <= scl_meta;
         scl_prev <= scl_sync;
         sda_meta <= SDA_IN;
         sda_sync <= sda_meta;
         sda_prev <= sda_sync;
      end
   end

   assign scl_rise  =  scl_sync & ~scl_prev;
   assign scl_fall  = ~scl_sync &  scl_prev;
   assign start_det =  scl_sync &  scl_prev &  sda_prev & ~sda_sync;
   assign stop_det  =  scl_sync &  scl_prev & ~sda_prev &  sda_sync;

   // Pointer increment with wrap, and out-of-range reads returning zero
   always_comb begin
      ptr_next = (ptr == LAST_ADDR) ? 8'h00 : ptr + 8'd1;
      rd_cur   = in_range(ptr)      ? regs[AW'(ptr)]      : 8'h00;
      rd_next  = in_range(ptr_next) ? regs[AW'(ptr_next)] : 8'h00;
   end

   // Protocol FSM, register file and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         SDA_OE       <= 1'b0;
         bus_wr_valid <= 1'b0;
         bus_wr_addr  <= 8'h00;
         bus_wr_data  <= 8'h00;
         busy         <= 1'b0;
         ptr          <= 8'h00;
         shift        <= 8'h00;
         tx_byte      <= 8'h00;
         bit_cnt      <= 4'd0;
         rw           <= 1'b0;
         regs         <= '{default: 8'h00};
      end else begin
         bus_wr_valid <= 1'b0;

         // Host write first so a same-cycle bus write to the same address wins
         if (host_wr_en && in_range(host_wr_addr)) begin
            regs[AW'(host_wr_addr)] <= host_wr_data;
         end

         if (start_det) begin
            // busy is held across a repeated START; the address byte decides
            state   <= ST_DEV_ADDR;
            SDA_OE  <= 1'b0;
            bit_cnt <= 4'd0;
         end else if (stop_det) begin
            state  <= ST_IDLE;
            SDA_OE <= 1'b0;
            busy   <= 1'b0;
         end else if (scl_rise) begin
            shift   <= {shift[6:0], sda_sync};
            bit_cnt <= bit_cnt + 4'd1;
            if (state == ST_RD_ACK) begin
               if (sda_sync) begin
                  state <= ST_WAIT_STOP;
                  busy  <= 1'b0;
               end else begin
                  ptr <= ptr_next;
               end
            end
         end else if (scl_fall) begin
            case (state)
               ST_DEV_ADDR: begin
                  if (bit_cnt == 4'd8) begin
                     if (shift[7:1] == DEV_ADDR) begin
                        state   <= ST_ADDR_ACK;
                        SDA_OE  <= 1'b1;
                        rw      <= shift[0];
                        busy    <= 1'b1;
                        tx_byte <= rd_cur;
                     end else begin
                        state <= ST_WAIT_STOP;
                        busy  <= 1'b0;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  bit_cnt <= 4'd0;
                  if (rw) begin
                     state  <= ST_RD_DATA;
                     SDA_OE <= ~tx_byte[7];
                  end else begin
                     state  <= ST_REG_ADDR;
                     SDA_OE <= 1'b0;
                  end
               end
               ST_REG_ADDR: begin
                  if (bit_cnt == 4'd8) begin
                     ptr    <= shift;
                     SDA_OE <= 1'b1;
                     state  <= ST_REG_ACK;
                  end
               end
               ST_REG_ACK: begin
                  SDA_OE  <= 1'b0;
                  bit_cnt <= 4'd0;
                  state   <= ST_WR_DATA;
               end
               ST_WR_DATA: begin
                  if (bit_cnt == 4'd8) begin
                     // Out-of-range bytes are still ACKed, just not stored
                     if (in_range(ptr)) begin
                        regs[AW'(ptr)] <= shift;
                        bus_wr_valid   <= 1'b1;
                        bus_wr_addr    <= ptr;
                        bus_wr_data    <= shift;
                     end
                     ptr    <= ptr_next;
                     SDA_OE <= 1'b1;
                     state  <= ST_WR_ACK;
                  end
               end
               ST_WR_ACK: begin
                  SDA_OE  <= 1'b0;
                  bit_cnt <= 4'd0;
                  state   <= ST_WR_DATA;
               end
               ST_RD_DATA: begin
                  if (bit_cnt == 4'd8) begin
                     // Byte done: release SDA and prefetch the following byte
                     SDA_OE  <= 1'b0;
                     tx_byte <= rd_next;
                     state   <= ST_RD_ACK;
                  end else begin
                     SDA_OE <= ~tx_byte[3'(4'd7 - bit_cnt)];
                  end
               end
               ST_RD_ACK: begin
                  // bit_cnt reaches 9 only when the ACK rising edge was seen
                  if (bit_cnt == 4'd9) begin
                     bit_cnt <= 4'd0;
                     SDA_OE  <= ~tx_byte[7];
                     state   <= ST_RD_DATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Directed testbench for i2c_target: drives an I2C controller model on an
// open-drain bus and checks ACKs, read data, write notifications and status.
module tb_i2c_target;

   localparam int unsigned Q = 8;  // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_ctrl;
   logic       sda_line;
   logic       sda_oe;
   logic       host_wr_en;
   logic [7:0] host_wr_addr;
   logic [7:0] host_wr_data;
   logic       bus_wr_valid;
   logic [7:0] bus_wr_addr;
   logic [7:0] bus_wr_data;
   logic       busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int         wr_count    = 0;
   int         oe_cycles   = 0;
   int         busy_cycles = 0;
   logic [7:0] wr_addr_log [64];
   logic [7:0] wr_data_log [64];

   always #5 clk = ~clk;

   assign sda_line = sda_ctrl & ~sda_oe;

   i2c_target #(.DEV_ADDR(7'h1D), .NUM_REGS(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .SCL_IN       (scl),
      .SDA_IN       (sda_line),
      .SDA_OE       (sda_oe),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .bus_wr_valid (bus_wr_valid),
      .bus_wr_addr  (bus_wr_addr),
      .bus_wr_data  (bus_wr_data),
      .busy         (busy)
   );

   // Record write pulses and count cycles with SDA driven / busy high
   always @(posedge clk) begin
      if (bus_wr_valid) begin
         wr_addr_log[wr_count[5:0]] <= bus_wr_addr;
         wr_data_log[wr_count[5:0]] <= bus_wr_data;
         wr_count <= wr_count + 1;
      end
      if (sda_oe) oe_cycles <= oe_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clock_bit(input logic drive, output logic sampled);
      wq(); sda_ctrl = drive;
      wq(); scl = 1'b1;
      wq(); sampled = sda_line;
      wq(); scl = 1'b0;
   endtask

   task automatic i2c_start();
      wq(); sda_ctrl = 1'b1;
      wq(); scl = 1'b1;
      wq(); sda_ctrl = 1'b0;
      wq(); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wq(); sda_ctrl = 1'b0;
      wq(); scl = 1'b1;
      wq(); sda_ctrl = 1'b1;
      wq();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack_n);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack_n);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         b[i] = s;
      end
      clock_bit(nack, s);
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
      @(negedge clk);
      host_wr_en = 1'b0;
   endtask

   task automatic read_one(input logic [7:0] r, output logic [7:0] d);
      logic a;
      i2c_start(); send_byte(8'h3A, a); send_byte(r, a);
      i2c_start(); send_byte(8'h3B, a); read_byte(1'b1, d);
      i2c_stop();
   endtask

   task automatic test_reset();
      rst = 1'b1; scl = 1'b1; sda_ctrl = 1'b1;
      host_wr_en = 1'b0; host_wr_addr = 8'h00; host_wr_data = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b exp 0", sda_oe); else pass_cnt++;
      total_cnt++; if (bus_wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b exp 0", bus_wr_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (bus_wr_addr !== 8'h00) $display("FAIL reset_wr_addr: got %h exp 00", bus_wr_addr); else pass_cnt++;
      total_cnt++; if (bus_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h exp 00", bus_wr_data); else pass_cnt++;
   endtask

   task automatic test_write();
      int w0;
      logic a0, a1, a2;
      logic [7:0] d;
      w0 = wr_count;
      i2c_start();
      send_byte(8'h3A, a0);
      send_byte(8'h2D, a1);
      total_cnt++; if (busy !== 1'b1) $display("FAIL write_busy_mid: got %b exp 1", busy); else pass_cnt++;
      send_byte(8'h08, a2);
      i2c_stop();
      total_cnt++; if (a0 !== 1'b0) $display("FAIL write_dev_ack: got %b exp 0", a0); else pass_cnt++;
      total_cnt++; if (a1 !== 1'b0) $display("FAIL write_reg_ack: got %b exp 0", a1); else pass_cnt++;
      total_cnt++; if (a2 !== 1'b0) $display("FAIL write_data_ack: got %b exp 0", a2); else pass_cnt++;
      total_cnt++; if (wr_count - w0 !== 1) $display("FAIL write_pulses: got %0d exp 1", wr_count - w0); else pass_cnt++;
      total_cnt++; if (wr_addr_log[w0[5:0]] !== 8'h2D) $display("FAIL write_addr: got %h exp 2d", wr_addr_log[w0[5:0]]); else pass_cnt++;
      total_cnt++; if (wr_data_log[w0[5:0]] !== 8'h08) $display("FAIL write_data: got %h exp 08", wr_data_log[w0[5:0]]); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b exp 0", busy); else pass_cnt++;
      read_one(8'h2D, d);
      total_cnt++; if (d !== 8'h08) $display("FAIL write_readback: got %h exp 08", d); else pass_cnt++;
   endtask

   task automatic test_read();
      logic a0, a1, a2;
      logic [7:0] d0, d1;
      host_write(8'h32, 8'hA5);
      host_write(8'h33, 8'h5A);
      i2c_start();
      send_byte(8'h3A, a0);
      send_byte(8'h32, a1);
      i2c_start();
      send_byte(8'h3B, a2);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      wq();
      total_cnt++; if (sda_oe !== 1'b0) $display("FAIL read_release_after_nack: got %b exp 0", sda_oe); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL read_busy_after_nack: got %b exp 0", busy); else pass_cnt++;
      i2c_stop();
      total_cnt++; if ({a0, a1, a2} !== 3'b000) $display("FAIL read_addr_acks: got %b exp 000", {a0, a1, a2}); else pass_cnt++;
      total_cnt++; if (d0 !== 8'hA5) $display("FAIL read_byte0: got %h exp a5", d0); else pass_cnt++;
      total_cnt++; if (d1 !== 8'h5A) $display("FAIL read_byte1: got %h exp 5a", d1); else pass_cnt++;
   endtask

   task automatic test_mismatch();
      int o0, b0;
      logic a0, a1;
      o0 = oe_cycles; b0 = busy_cycles;
      i2c_start();
      send_byte(8'hA6, a0);
      send_byte(8'h55, a1);
      i2c_stop();
      total_cnt++; if (a0 !== 1'b1) $display("FAIL mismatch_addr_nack: got %b exp 1", a0); else pass_cnt++;
      total_cnt++; if (a1 !== 1'b1) $display("FAIL mismatch_data_nack: got %b exp 1", a1); else pass_cnt++;
      total_cnt++; if (oe_cycles - o0 !== 0) $display("FAIL mismatch_sda_oe: got %0d cycles exp 0", oe_cycles - o0); else pass_cnt++;
      total_cnt++; if (busy_cycles - b0 !== 0) $display("FAIL mismatch_busy: got %0d cycles exp 0", busy_cycles - b0); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int w0;
      logic a;
      logic [7:0] d;
      w0 = wr_count;
      i2c_start();
      send_byte(8'h3A, a); send_byte(8'h3F, a);
      send_byte(8'h11, a); send_byte(8'h22, a);
      i2c_stop();
      total_cnt++; if (wr_count - w0 !== 2) $display("FAIL wrap_pulses: got %0d exp 2", wr_count - w0); else pass_cnt++;
      total_cnt++; if (wr_addr_log[w0[5:0]] !== 8'h3F) $display("FAIL wrap_addr0: got %h exp 3f", wr_addr_log[w0[5:0]]); else pass_cnt++;
      total_cnt++; if (wr_addr_log[6'(w0 + 1)] !== 8'h00) $display("FAIL wrap_addr1: got %h exp 00", wr_addr_log[6'(w0 + 1)]); else pass_cnt++;
      total_cnt++; if (wr_data_log[6'(w0 + 1)] !== 8'h22) $display("FAIL wrap_data1: got %h exp 22", wr_data_log[6'(w0 + 1)]); else pass_cnt++;
      read_one(8'h3F, d);
      total_cnt++; if (d !== 8'h11) $display("FAIL wrap_read_3f: got %h exp 11", d); else pass_cnt++;
      read_one(8'h00, d);
      total_cnt++; if (d !== 8'h22) $display("FAIL wrap_read_00: got %h exp 22", d); else pass_cnt++;
   endtask

   task automatic test_out_of_range();
      int w0;
      logic a0, a1;
      logic [7:0] d;
      w0 = wr_count;
      i2c_start();
      send_byte(8'h3A, a0); send_byte(8'h80, a0); send_byte(8'h77, a1);
      i2c_stop();
      total_cnt++; if (a0 !== 1'b0) $display("FAIL oor_reg_ack: got %b exp 0", a0); else pass_cnt++;
      total_cnt++; if (a1 !== 1'b0) $display("FAIL oor_data_ack: got %b exp 0", a1); else pass_cnt++;
      total_cnt++; if (wr_count - w0 !== 0) $display("FAIL oor_pulses: got %0d exp 0", wr_count - w0); else pass_cnt++;
      read_one(8'h80, d);
      total_cnt++; if (d !== 8'h00) $display("FAIL oor_read: got %h exp 00", d); else pass_cnt++;
   endtask

   task automatic test_inflight();
      logic a;
      logic [7:0] d;
      host_write(8'h05, 8'hC3);
      i2c_start();
      send_byte(8'h3A, a); send_byte(8'h05, a);
      i2c_start();
      send_byte(8'h3B, a);
      host_write(8'h05, 8'h3C);
      read_byte(1'b1, d);
      i2c_stop();
      total_cnt++; if (a !== 1'b0) $display("FAIL inflight_ack: got %b exp 0", a); else pass_cnt++;
      total_cnt++; if (d !== 8'hC3) $display("FAIL inflight_byte: got %h exp c3", d); else pass_cnt++;
      read_one(8'h05, d);
      total_cnt++; if (d !== 8'h3C) $display("FAIL inflight_host_wr: got %h exp 3c", d); else pass_cnt++;
   endtask

   task automatic test_stop_mid();
      int w0;
      logic a, s;
      logic [7:0] d;
      w0 = wr_count;
      i2c_start();
      send_byte(8'h3A, a); send_byte(8'h10, a);
      for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
      i2c_stop();
      wq();
      total_cnt++; if (wr_count - w0 !== 0) $display("FAIL stopmid_pulses: got %0d exp 0", wr_count - w0); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL stopmid_busy: got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (sda_oe !== 1'b0) $display("FAIL stopmid_sda_oe: got %b exp 0", sda_oe); else pass_cnt++;
      read_one(8'h10, d);
      total_cnt++; if (d !== 8'h00) $display("FAIL stopmid_reg: got %h exp 00", d); else pass_cnt++;
   endtask

   task automatic test_rst_mid();
      int w0, o0;
      logic a, s;
      logic [7:0] d;
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] b;
         b = 8'h3A;
         clock_bit(b[i], s);
      end
      wq();
      total_cnt++; if (sda_oe !== 1'b1) $display("FAIL rstmid_ack_driven: got %b exp 1", sda_oe); else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      total_cnt++; if (sda_oe !== 1'b0) $display("FAIL rstmid_release: got %b exp 0", sda_oe); else pass_cnt++;
      rst = 1'b0;
      w0 = wr_count; o0 = oe_cycles;
      clock_bit(1'b1, s);
      send_byte(8'h2D, a);
      send_byte(8'h99, a);
      i2c_stop();
      total_cnt++; if (oe_cycles - o0 !== 0) $display("FAIL rstmid_ignored_oe: got %0d cycles exp 0", oe_cycles - o0); else pass_cnt++;
      total_cnt++; if (wr_count - w0 !== 0) $display("FAIL rstmid_ignored_wr: got %0d exp 0", wr_count - w0); else pass_cnt++;
      read_one(8'h32, d);
      total_cnt++; if (d !== 8'h00) $display("FAIL rstmid_regs_cleared: got %h exp 00", d); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_wrap();
      test_out_of_range();
      test_inflight();
      test_stop_mid();
      test_rst_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
